// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the arb_rtl arbiter family.
//   arb_state_e       : arbiter FSM states (IDLE, GRANT, GAP)
//   C_CNT_WIDTH       : width of the grant hold counter
//   C_MAX_NUM_REQ     : largest supported requester count
//   C_MAX_OWNER_WIDTH : owner/pointer width at C_MAX_NUM_REQ
//   clog2()           : ceiling log2, used to size owner/pointer fields
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int C_CNT_WIDTH       = 16;
  localparam int C_MAX_NUM_REQ     = 16;
  localparam int C_MAX_OWNER_WIDTH = 4;

  // Smallest r with 2**r >= value. Evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational rotate-priority encoder. Starting just after i_ptr and
// wrapping modulo C_NUM_REQ, returns the first asserted request.
// Ports:
//   i_req    [C_NUM_REQ]   request vector
//   i_ptr    [C_IDX_WIDTH] index of the lowest-priority requester
//   o_valid                at least one request is set
//   o_index  [C_IDX_WIDTH] winning requester index (0 when !o_valid)
//   o_onehot [C_NUM_REQ]   winning requester as a one-hot vector
// -----------------------------------------------------------------------------
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int C_NUM_REQ   = 4,
  parameter int C_IDX_WIDTH = clog2(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0]   i_req,
  input  logic [C_IDX_WIDTH-1:0] i_ptr,
  output logic                   o_valid,
  output logic [C_IDX_WIDTH-1:0] o_index,
  output logic [C_NUM_REQ-1:0]   o_onehot
);

  int                   w_cand;
  logic [C_IDX_WIDTH-1:0] w_cand_idx;

  // Visit ptr+1, ptr+2, ..., ptr+N (mod N); the last visited is ptr itself,
  // so the previous owner only wins when nobody else is asking. The explicit
  // modulo keeps non-power-of-two counts from ever producing an index >= N.
  always_comb begin
    o_valid    = 1'b0;
    o_index    = '0;
    o_onehot   = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      w_cand     = (int'(i_ptr) + k) % C_NUM_REQ;
      w_cand_idx = w_cand[C_IDX_WIDTH-1:0];
      if (!o_valid && i_req[w_cand_idx]) begin
        o_valid              = 1'b1;
        o_index              = w_cand_idx;
        o_onehot[w_cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// arb_rr_arbiter
// Round-robin arbiter for the S_ARB side of the REQ/GNT/REL interface.
// Grants one requester at a time and holds the grant until the owner
// releases, abandons (drops its request) or, optionally, times out. Every
// grant is followed by one dead GAP cycle before the next arbitration.
//
// Handshake: s_req[i] is a level; a grant is issued only from IDLE and is
// held in GRANT. Only the owner's s_rel/s_req bits are looked at, and only
// in GRANT; all s_rel activity elsewhere is ignored. s_gnt is registered.
//
// Ports:
//   aclk        clock, rising edge
//   areset      synchronous active-high reset
//   s_req       [C_NUM_REQ]     per-requester request level
//   s_rel       [C_NUM_REQ]     per-requester release (pulse or level)
//   s_gnt       [C_NUM_REQ]     one-hot registered grant
//   busy                        high while a grant is held
//   owner       [C_OWNER_WIDTH] current or most recent owner
//   timeout_evt                 one-cycle pulse after a forced revoke
//   dbg_state   [2]             FSM state (arb_state_e encoding)
// -----------------------------------------------------------------------------
module arb_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int C_NUM_REQ      = 4,
  parameter  int C_HOLD_TIMEOUT = 0,
  localparam int C_OWNER_WIDTH  = clog2(C_NUM_REQ)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [C_NUM_REQ-1:0]     s_req,
  input  logic [C_NUM_REQ-1:0]     s_rel,
  output logic [C_NUM_REQ-1:0]     s_gnt,
  output logic                     busy,
  output logic [C_OWNER_WIDTH-1:0] owner,
  output logic                     timeout_evt,
  output logic [1:0]               dbg_state
);

  // Pointer reset value: the last index, so requester 0 is searched first.
  localparam logic [C_OWNER_WIDTH-1:0] C_PTR_RST = C_OWNER_WIDTH'(C_NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  arb_state_e               r_state;
  logic [C_NUM_REQ-1:0]     r_gnt;
  logic                     r_busy;
  logic [C_OWNER_WIDTH-1:0] r_owner;
  logic [C_OWNER_WIDTH-1:0] r_ptr;
  logic                     r_evt;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  arb_state_e               w_state_nxt;
  logic [C_NUM_REQ-1:0]     w_gnt_nxt;
  logic                     w_busy_nxt;
  logic [C_OWNER_WIDTH-1:0] w_owner_nxt;
  logic [C_OWNER_WIDTH-1:0] w_ptr_nxt;
  logic                     w_evt_nxt;

  logic                     w_pick_valid;
  logic [C_OWNER_WIDTH-1:0] w_pick_index;
  logic [C_NUM_REQ-1:0]     w_pick_onehot;

  logic                     w_rel;
  logic                     w_abandon;
  logic                     w_timeout_hit;
  logic                     w_exit;

  // ---------------------------------------------------------------------------
  // Rotate-priority selection
  // ---------------------------------------------------------------------------
  arb_rr_pick #(
    .C_NUM_REQ   (C_NUM_REQ),
    .C_IDX_WIDTH (C_OWNER_WIDTH)
  ) u_pick (
    .i_req    (s_req),
    .i_ptr    (r_ptr),
    .o_valid  (w_pick_valid),
    .o_index  (w_pick_index),
    .o_onehot (w_pick_onehot)
  );

  // Only the owner's bits matter; non-owner release pulses are ignored.
  assign w_rel     = s_rel[r_owner];
  assign w_abandon = ~s_req[r_owner];

  // ---------------------------------------------------------------------------
  // Hold counter. Zero whenever not in GRANT, so it is already clear on the
  // first GRANT cycle. Firing at T-1 means the grant is visible for exactly T
  // cycles. It saturates rather than wrapping.
  // ---------------------------------------------------------------------------
  generate
    if (C_HOLD_TIMEOUT > 0) begin : g_timeout
      localparam logic [C_CNT_WIDTH-1:0] C_LIMIT = C_CNT_WIDTH'(C_HOLD_TIMEOUT - 1);
      localparam logic [C_CNT_WIDTH-1:0] C_SAT   = '1;

      logic [C_CNT_WIDTH-1:0] r_cnt;

      always_ff @(posedge aclk) begin
        if (areset) begin
          r_cnt <= '0;
        end else if (r_state != GRANT) begin
          r_cnt <= '0;
        end else if (r_cnt != C_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_timeout_hit = (r_state == GRANT) && (r_cnt == C_LIMIT);
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  assign w_exit = w_rel | w_abandon | w_timeout_hit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= C_PTR_RST;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_evt   <= w_evt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_evt_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick_onehot;
          w_busy_nxt  = 1'b1;
          w_owner_nxt = w_pick_index;
        end
      end

      GRANT: begin
        if (w_exit) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          // Departing owner becomes lowest priority for the next round.
          w_ptr_nxt   = r_owner;
          // A voluntary exit in the same cycle wins over the timeout.
          w_evt_nxt   = w_timeout_hit & ~w_rel & ~w_abandon;
        end
      end

      GAP: begin
        // Single dead cycle; requests are deliberately not sampled here.
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_gnt       = r_gnt;
  assign busy        = r_busy;
  assign owner       = r_owner;
  assign timeout_evt = (C_HOLD_TIMEOUT > 0) ? r_evt : 1'b0;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_arbiter
// Three arbiter instances share one set of request/release inputs:
//   sel 0 : C_NUM_REQ=4, no timeout
//   sel 1 : C_NUM_REQ=3, no timeout
//   sel 2 : C_NUM_REQ=4, C_HOLD_TIMEOUT=5
// The driver applies one directed vector per cycle and queues the outputs
// expected after that edge; the monitor compares the selected instance
// half a cycle later.
// -----------------------------------------------------------------------------
module tb_arb_rr_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic aclk;
  logic areset;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  logic [3:0] s_req;
  logic [3:0] s_rel;
  int         sel;

  // Instance 0
  logic [3:0] gnt0;
  logic       busy0;
  logic [1:0] owner0;
  logic       evt0;
  logic [1:0] st0;

  // Instance 1
  logic [2:0] gnt1;
  logic       busy1;
  logic [1:0] owner1;
  logic       evt1;
  logic [1:0] st1;

  // Instance 2
  logic [3:0] gnt2;
  logic       busy2;
  logic [1:0] owner2;
  logic       evt2;
  logic [1:0] st2;

  arb_rr_arbiter #(.C_NUM_REQ(4), .C_HOLD_TIMEOUT(0)) u_dut4 (
    .aclk        (aclk),
    .areset      (areset),
    .s_req       (s_req),
    .s_rel       (s_rel),
    .s_gnt       (gnt0),
    .busy        (busy0),
    .owner       (owner0),
    .timeout_evt (evt0),
    .dbg_state   (st0)
  );

  arb_rr_arbiter #(.C_NUM_REQ(3), .C_HOLD_TIMEOUT(0)) u_dut3 (
    .aclk        (aclk),
    .areset      (areset),
    .s_req       (s_req[2:0]),
    .s_rel       (s_rel[2:0]),
    .s_gnt       (gnt1),
    .busy        (busy1),
    .owner       (owner1),
    .timeout_evt (evt1),
    .dbg_state   (st1)
  );

  arb_rr_arbiter #(.C_NUM_REQ(4), .C_HOLD_TIMEOUT(5)) u_dut_to (
    .aclk        (aclk),
    .areset      (areset),
    .s_req       (s_req),
    .s_rel       (s_rel),
    .s_gnt       (gnt2),
    .busy        (busy2),
    .owner       (owner2),
    .timeout_evt (evt2),
    .dbg_state   (st2)
  );

  // Selected instance outputs
  logic [3:0] act_gnt;
  logic       act_busy;
  logic [1:0] act_owner;
  logic       act_evt;

  always_comb begin
    act_gnt   = gnt0;
    act_busy  = busy0;
    act_owner = owner0;
    act_evt   = evt0;
    if (sel == 1) begin
      act_gnt   = {1'b0, gnt1};
      act_busy  = busy1;
      act_owner = owner1;
      act_evt   = evt1;
    end else if (sel == 2) begin
      act_gnt   = gnt2;
      act_busy  = busy2;
      act_owner = owner2;
      act_evt   = evt2;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: {gnt[3:0], busy, owner[1:0], evt}
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_checks;
  int         n_fail;
  logic [7:0] mon_exp;
  string      mon_name;
  logic       mon_bad;

  always @(negedge aclk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_checks = n_checks + 1;
      mon_bad  = 1'b0;
      if (act_gnt !== mon_exp[7:4]) mon_bad = 1'b1;
      if (act_busy !== mon_exp[3]) mon_bad = 1'b1;
      if (act_owner !== mon_exp[2:1]) mon_bad = 1'b1;
      if (act_evt !== mon_exp[0]) mon_bad = 1'b1;
      if (mon_bad) begin
        n_fail = n_fail + 1;
        $display("FAIL %s (sel %0d): got gnt=%b busy=%b owner=%0d evt=%b, expected gnt=%b busy=%b owner=%0d evt=%b",
                 mon_name, sel, act_gnt, act_busy, act_owner, act_evt,
                 mon_exp[7:4], mon_exp[3], mon_exp[2:1], mon_exp[0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] rel,
                      input logic [3:0] e_gnt, input logic e_busy,
                      input logic [1:0] e_owner, input logic e_evt, input string nm);
    areset = rst;
    s_req  = req;
    s_rel  = rel;
    @(posedge aclk);
    #1;
    exp_q.push_back({e_gnt, e_busy, e_owner, e_evt});
    name_q.push_back(nm);
  endtask

  // Switch the observed instance only after the pending check is done.
  task automatic select(input int s);
    @(negedge aclk);
    #1;
    sel = s;
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, nm);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [3:0] oh;
  logic [1:0] ow;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    areset   = 1'b1;
    s_req    = 4'h0;
    s_rel    = 4'h0;

    // Basic grant, release, gap, abandon (N=4)
    do_reset("basic_reset");
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "basic_grant");
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "basic_hold");
    step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "basic_release");
    step(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "basic_gap");
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "basic_regrant");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "basic_abandon");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "basic_idle");

    // Round robin with all requesting; order 0,1,2,3,0
    do_reset("rr_reset");
    for (int k = 0; k < 5; k++) begin
      ow = 2'(k % 4);
      oh = 4'b0001 << ow;
      step(1'b0, 4'hF, 4'h0, oh,   1'b1, ow, 1'b0, "rr_grant");
      step(1'b0, 4'hF, ~oh,  oh,   1'b1, ow, 1'b0, "rr_nonowner_rel");
      step(1'b0, 4'hF, 4'h0, oh,   1'b1, ow, 1'b0, "rr_hold");
      step(1'b0, 4'hF, oh,   4'h0, 1'b0, ow, 1'b0, "rr_release");
      step(1'b0, 4'hF, 4'h0, 4'h0, 1'b0, ow, 1'b0, "rr_gap");
    end

    // Reset in the middle of a grant
    do_reset("mid_pre_reset");
    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "mid_grant2");
    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "mid_hold2");
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "mid_reset");
    step(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "post_reset_grant0");

    // Three requesters, non-power-of-two wrap
    select(1);
    do_reset("n3_reset");
    step(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "n3_grant0");
    step(1'b0, 4'b0101, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "n3_rel0");
    step(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "n3_gap0");
    step(1'b0, 4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, "n3_grant2");
    step(1'b0, 4'b0101, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, "n3_rel2");
    step(1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, "n3_gap2");
    step(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "n3_wrap_grant0");
    step(1'b0, 4'b0101, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "n3_rel0b");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "n3_gap0b");
    step(1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "n3_no_req");

    // Hold timeout of 5 cycles
    select(2);
    do_reset("to_reset");
    step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "to_grant0");
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "to_hold0");
    step(1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, "to_expire0");
    step(1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "to_gap0");
    step(1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, "to_grant1");
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, "to_hold1");
    step(1'b0, 4'b0011, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0, "to_rel_at_limit");
    step(1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, "to_gap1");
    step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, "to_regrant0");
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "to_abandon");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "to_idle");

    @(negedge aclk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    if (n_checks == 0) begin
      n_fail = n_fail + 1;
      $display("FAIL check_count: got 0 checks, expected more than 0");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
